image_slideshow_ctrl: RTL and testbench

IMAGE_SLIDESHOW_CTRL -- requirements
Module: image_slideshow_ctrl

---
 rtl/image_slideshow_ctrl.sv | 147 ++++++++++++++
 tb/tb_image_slideshow_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/image_slideshow_ctrl.sv
// Image slideshow sequencer: steps through NUM_IMAGES images on user pulses or a dwell
// timer, requesting a load for each new image and waiting for the loader's acknowledge.
module image_slideshow_ctrl #(
  parameter int NUM_IMAGES   = 4,
  parameter int IDX_W        = 2,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_pulse,
  input  logic             prev_pulse,
  input  logic             auto_en,
  input  logic             load_done,
  output logic [IDX_W-1:0] image_index,
  output logic             load_req,
  output logic             showing
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_FWD  = 2'd1,
    PEND_BACK = 2'd2
  } pend_t;

  state_t           state_r;
  pend_t            pend_r;
  logic [CNT_W-1:0] cnt_r;
  logic             step_s;
  logic             step_fwd_s;
  logic             expiry_s;

  function automatic logic [IDX_W-1:0] idx_fwd(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_IMAGES - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  function automatic logic [IDX_W-1:0] idx_back(input logic [IDX_W-1:0] idx);
    if (idx == {IDX_W{1'b0}}) begin
      return IDX_W'(NUM_IMAGES - 1);
    end else begin
      return idx - IDX_W'(1);
    end
  endfunction

  // Step source selection for SHOW: pending > next > prev > dwell expiry
  always_comb begin
    step_s     = 1'b0;
    step_fwd_s = 1'b0;
    expiry_s   = auto_en && (cnt_r == CNT_W'(DWELL_CYCLES - 1));
    case (pend_r)
      PEND_FWD: begin
        step_s     = 1'b1;
        step_fwd_s = 1'b1;
      end
      PEND_BACK: begin
        step_s     = 1'b1;
        step_fwd_s = 1'b0;
      end
      default: begin
        if (next_pulse) begin
          step_s     = 1'b1;
          step_fwd_s = 1'b1;
        end else if (prev_pulse) begin
          step_s     = 1'b1;
          step_fwd_s = 1'b0;
        end else if (expiry_s) begin
          step_s     = 1'b1;
          step_fwd_s = 1'b1;
        end else begin
          step_s     = 1'b0;
          step_fwd_s = 1'b0;
        end
      end
    endcase
  end

  // Sequencer FSM with registered outputs, dwell counter and one-deep pending step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= INIT;
      pend_r      <= PEND_NONE;
      cnt_r       <= {CNT_W{1'b0}};
      image_index <= {IDX_W{1'b0}};
      load_req    <= 1'b0;
      showing     <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          state_r  <= LOAD;
          load_req <= 1'b1;
          showing  <= 1'b0;
          cnt_r    <= {CNT_W{1'b0}};
        end
        LOAD: begin
          // Pulses during a load are remembered; the latest wins, next beats prev
          if (next_pulse) begin
            pend_r <= PEND_FWD;
          end else if (prev_pulse) begin
            pend_r <= PEND_BACK;
          end else begin
            pend_r <= pend_r;
          end
          if (load_done) begin
            state_r  <= SHOW;
            load_req <= 1'b0;
            showing  <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
          end else begin
            state_r  <= LOAD;
          end
        end
        SHOW: begin
          if (step_s) begin
            image_index <= step_fwd_s ? idx_fwd(image_index) : idx_back(image_index);
            state_r     <= LOAD;
            load_req    <= 1'b1;
            showing     <= 1'b0;
            pend_r      <= PEND_NONE;
            cnt_r       <= {CNT_W{1'b0}};
          end else if (auto_en) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        default: begin
          state_r  <= INIT;
          pend_r   <= PEND_NONE;
          cnt_r    <= {CNT_W{1'b0}};
          load_req <= 1'b0;
          showing  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_slideshow_ctrl.sv
// Directed table-driven bench for image_slideshow_ctrl (NUM_IMAGES=4, DWELL_CYCLES=5).
module tb_image_slideshow_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       next_pulse;
  logic       prev_pulse;
  logic       auto_en;
  logic       load_done;
  logic [1:0] image_index;
  logic       load_req;
  logic       showing;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       nx;
    logic       pv;
    logic       au;
    logic       ld;
    logic [1:0] idx;
    logic       lr;
    logic       sh;
  } vec_t;

  vec_t vecs[$];

  image_slideshow_ctrl #(
    .NUM_IMAGES  (4),
    .IDX_W       (2),
    .DWELL_CYCLES(5),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .next_pulse (next_pulse),
    .prev_pulse (prev_pulse),
    .auto_en    (auto_en),
    .load_done  (load_done),
    .image_index(image_index),
    .load_req   (load_req),
    .showing    (showing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input int lr, input int sh);
    check({tag, ".image_index"}, int'(image_index), idx);
    check({tag, ".load_req"}, int'(load_req), lr);
    check({tag, ".showing"}, int'(showing), sh);
  endtask

  task automatic add(input logic nx, input logic pv, input logic au, input logic ld,
                     input logic [1:0] idx, input logic lr, input logic sh);
    vec_t v;
    v.nx = nx; v.pv = pv; v.au = au; v.ld = ld;
    v.idx = idx; v.lr = lr; v.sh = sh;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic nx, input logic pv, input logic au, input logic ld);
    next_pulse = nx;
    prev_pulse = pv;
    auto_en    = au;
    load_done  = ld;
  endtask

  initial begin
    // Expected outputs are those seen just after the edge that consumes each row.
    //   nx    pv    au    ld    idx    lr    sh
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0); // INIT -> LOAD 0
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1); // done 3 cycles after load_req
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); // next
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0); // next+prev -> next
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1); // load_done in SHOW ignored
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0); // 3 -> 0 wrap
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0); // 0 -> 3 wrap back
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); // LOAD of 1
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); // prev pending, index held
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); // next overwrites pending
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1); // one SHOW cycle
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0); // pending fwd applied
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // dwell counts 0..4
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0); // expiry after 5 SHOW cycles
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1); // auto off clears counter
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0); // full dwell from 0 again
    add(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1); // pulse with load_done -> pending
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0); // pending back
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0); // pending beats next
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1); // pending consumed
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      add(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0); // no expiry while loading
    end
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs("first_edge_load", 0, 1, 0);

    // Replay from reset so row 0 is the INIT -> LOAD edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    check_outs("init_after_release", 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].nx, vecs[i].pv, vecs[i].au, vecs[i].ld);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), int'(vecs[i].idx), int'(vecs[i].lr), int'(vecs[i].sh));
      @(negedge clk);
    end

    // Async reset mid-LOAD at index 2
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("pre_abort_load", 2, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_abort", 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("held_in_reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs("reload_image0", 0, 1, 0);

    // Async reset mid-SHOW
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_outs("show_before_abort", 0, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_abort_show", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs("reload_after_show", 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
